trap_unit: RTL and testbench

- Machine-mode trap controller and responder for the CSR file's delegated trap CSR port (mtvec, mie, mip, mepc, mcause, mtval).
- Arbitrates synchronous exceptions against enabled interrupts and captures trap state.
- Issues a one-cycle trap/redirect to the fetch stage; also services mret redirects to mepc.
- Sits beside the CSR file in the core; the CSR file drives its trap_rd_en/trap_wr_en into this block and reads trap_rd_data back.

---
 rtl/trap_unit.sv | 174 +++++++++++++++++
 tb/tb_trap_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_unit.sv
// Machine-mode trap controller: arbitrates exceptions against enabled interrupts, owns the trap CSRs, and issues trap/mret redirects.
// Optional macro TRAP_VECTORED_EN enables mtvec MODE=1 (vectored interrupts); when undefined, MODE is hardwired to 0.
module trap_unit #(
    parameter logic [31:0] MTVEC_RESET     = 32'h0000_0000,
    parameter int          IRQ_SYNC_STAGES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_rd_en,
    input  logic        csr_wr_en,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wr_data,
    output logic [31:0] csr_rd_data,
    input  logic        global_mie,
    input  logic        stall,
    input  logic [31:0] pc,
    input  logic        exc_req,
    input  logic [3:0]  exc_cause,
    input  logic [31:0] exc_tval,
    input  logic        mret,
    input  logic        irq_ext,
    input  logic        irq_sw,
    input  logic        irq_timer,
    output logic        trap,
    output logic        redirect,
    output logic [31:0] redirect_pc
);

    localparam logic [11:0] ADDR_MIE    = 12'h304;
    localparam logic [11:0] ADDR_MTVEC  = 12'h305;
    localparam logic [11:0] ADDR_MEPC   = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE = 12'h342;
    localparam logic [11:0] ADDR_MTVAL  = 12'h343;
    localparam logic [11:0] ADDR_MIP    = 12'h344;
    localparam logic [31:0] MIE_MASK    = 32'h0000_0888;

    typedef enum logic [1:0] {RUN, TRAP, RET} state_t;

    state_t      state, next_state;
    logic [2:0]  irq_sync [IRQ_SYNC_STAGES];
    logic [31:0] mip, mie, mepc, mcause, mtval, irq_active;
    logic [29:0] mtvec_base;
    logic [1:0]  mtvec_mode;
    logic [3:0]  irq_code;
    logic        irq_pend, take;

    // Each sync stage holds {ext, sw, timer}; the last stage is what mip exposes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < IRQ_SYNC_STAGES; i++) irq_sync[i] <= 3'b000;
        end else begin
            irq_sync[0] <= {irq_ext, irq_sw, irq_timer};
            for (int i = 1; i < IRQ_SYNC_STAGES; i++) irq_sync[i] <= irq_sync[i-1];
        end
    end

    assign mip = {20'b0, irq_sync[IRQ_SYNC_STAGES-1][2], 3'b0,
                  irq_sync[IRQ_SYNC_STAGES-1][0], 3'b0,
                  irq_sync[IRQ_SYNC_STAGES-1][1], 3'b0};

    assign irq_active = mip & mie;
    assign irq_pend   = (|irq_active) & global_mie;
    assign take       = (exc_req | irq_pend) & ~stall & (state == RUN);

    // Interrupt priority: external, then software, then timer.
    always_comb begin
        irq_code = 4'd0;
        if (irq_active[11])     irq_code = 4'd11;
        else if (irq_active[3]) irq_code = 4'd3;
        else if (irq_active[7]) irq_code = 4'd7;
    end

`ifdef TRAP_VECTORED_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            mtvec_mode <= MTVEC_RESET[1:0];
        end else if (csr_wr_en && csr_addr == ADDR_MTVEC && !csr_wr_data[1]) begin
            mtvec_mode <= csr_wr_data[1:0];
        end
    end
`else
    assign mtvec_mode = 2'b00;
`endif

    // Trap capture is placed after the CSR write so it overrides a same-cycle write.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtvec_base <= MTVEC_RESET[31:2];
            mie        <= 32'h0;
            mepc       <= 32'h0;
            mcause     <= 32'h0;
            mtval      <= 32'h0;
        end else begin
            if (csr_wr_en) begin
                case (csr_addr)
                    ADDR_MTVEC:  mtvec_base <= csr_wr_data[31:2];
                    ADDR_MIE:    mie        <= csr_wr_data & MIE_MASK;
                    ADDR_MEPC:   mepc       <= csr_wr_data & ~32'h3;
                    ADDR_MCAUSE: mcause     <= csr_wr_data;
                    ADDR_MTVAL:  mtval      <= csr_wr_data;
                    default: ;
                endcase
            end
            if (take) begin
                mepc <= pc & ~32'h3;
                if (exc_req) begin
                    mcause <= {28'b0, exc_cause};
                    mtval  <= exc_tval;
                end else begin
                    mcause <= {1'b1, 27'b0, irq_code};
                    mtval  <= 32'h0;
                end
            end
        end
    end

    always_comb begin
        csr_rd_data = 32'h0;
        if (csr_rd_en) begin
            case (csr_addr)
                ADDR_MTVEC:  csr_rd_data = {mtvec_base, mtvec_mode};
                ADDR_MIE:    csr_rd_data = mie;
                ADDR_MIP:    csr_rd_data = mip;
                ADDR_MEPC:   csr_rd_data = mepc;
                ADDR_MCAUSE: csr_rd_data = mcause;
                ADDR_MTVAL:  csr_rd_data = mtval;
                default:     csr_rd_data = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= next_state;
    end

    always_comb begin
        next_state = RUN;
        case (state)
            RUN: begin
                if (take)                next_state = TRAP;
                else if (mret && !stall) next_state = RET;
                else                     next_state = RUN;
            end
            TRAP:    next_state = RUN;
            RET:     next_state = RUN;
            default: next_state = RUN;
        endcase
    end

    // Outputs depend only on registered state; reset suppresses a pulse already in flight.
    always_comb begin
        trap        = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        if (!rst) begin
            case (state)
                TRAP: begin
                    trap        = 1'b1;
                    redirect    = 1'b1;
                    redirect_pc = {mtvec_base, 2'b00};
                    if (mtvec_mode == 2'd1 && mcause[31])
                        redirect_pc = {mtvec_base, 2'b00} + {mcause[29:0], 2'b00};
                end
                RET: begin
                    redirect    = 1'b1;
                    redirect_pc = mepc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_trap_unit.sv
// Self-checking bench for trap_unit: directed scenarios followed by randomized traffic against a behavioural model.
module tb_trap_unit;

    localparam logic [31:0] MTVEC_RST = 32'h0000_0100;
    localparam int          SYNC      = 1;

    logic        clk = 1'b0;
    logic        rst, csr_rd_en, csr_wr_en, global_mie, stall, exc_req, mret;
    logic        irq_ext, irq_sw, irq_timer, trap, redirect;
    logic [11:0] csr_addr;
    logic [31:0] csr_wr_data, csr_rd_data, pc, exc_tval, redirect_pc;
    logic [3:0]  exc_cause;

    logic [31:0] m_mtvec, m_mie, m_mepc, m_mcause, m_mtval;
    logic [2:0]  m_hist [SYNC];
    int          exp_kind;
    int          total = 0;
    int          bad = 0;
    logic [31:0] vec_expect;

    trap_unit #(.MTVEC_RESET(MTVEC_RST), .IRQ_SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst(rst), .csr_rd_en(csr_rd_en), .csr_wr_en(csr_wr_en),
        .csr_addr(csr_addr), .csr_wr_data(csr_wr_data), .csr_rd_data(csr_rd_data),
        .global_mie(global_mie), .stall(stall), .pc(pc), .exc_req(exc_req),
        .exc_cause(exc_cause), .exc_tval(exc_tval), .mret(mret),
        .irq_ext(irq_ext), .irq_sw(irq_sw), .irq_timer(irq_timer),
        .trap(trap), .redirect(redirect), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] modelMip();
        logic [31:0] v = 32'h0;
        if (m_hist[SYNC-1][2]) v |= 32'h800;
        if (m_hist[SYNC-1][1]) v |= 32'h008;
        if (m_hist[SYNC-1][0]) v |= 32'h080;
        return v;
    endfunction

    function automatic logic [31:0] modelRead(input logic [11:0] a);
        case (a)
            12'h305: return m_mtvec;
            12'h304: return m_mie;
            12'h344: return modelMip();
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] modelTarget();
        logic [31:0] base = m_mtvec & ~32'h3;
        if (m_mtvec[1:0] == 2'd1 && m_mcause[31]) return base + 4 * (m_mcause & 32'h7fff_ffff);
        return base;
    endfunction

    // Advance the reference model by one clock using the inputs currently driven.
    task automatic modelStep();
        logic [31:0] act;
        logic        pend, flushing, take, ret, found;
        int          prio [3] = '{11, 3, 7};
        int          code;
        if (rst) begin
            m_mtvec = MTVEC_RST;
`ifndef TRAP_VECTORED_EN
            m_mtvec[1:0] = 2'b00;
`endif
            m_mie = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
            exp_kind = 0;
            for (int i = 0; i < SYNC; i++) m_hist[i] = 3'b000;
            return;
        end
        flushing = (exp_kind != 0);
        act  = modelMip() & m_mie;
        pend = global_mie && (act != 0);
        take = !flushing && !stall && (exc_req || pend);
        ret  = !flushing && !stall && !take && mret;
        if (csr_wr_en) begin
            case (csr_addr)
                12'h305: begin
                    m_mtvec[31:2] = csr_wr_data[31:2];
`ifdef TRAP_VECTORED_EN
                    if (csr_wr_data[1:0] < 2) m_mtvec[1:0] = csr_wr_data[1:0];
`endif
                end
                12'h304: m_mie    = csr_wr_data & 32'h888;
                12'h341: m_mepc   = csr_wr_data & ~32'h3;
                12'h342: m_mcause = csr_wr_data;
                12'h343: m_mtval  = csr_wr_data;
                default: ;
            endcase
        end
        if (take) begin
            m_mepc = pc & ~32'h3;
            if (exc_req) begin
                m_mcause = 32'(exc_cause);
                m_mtval  = exc_tval;
            end else begin
                found = 1'b0;
                code  = 0;
                for (int i = 0; i < 3; i++)
                    if (!found && act[prio[i]]) begin code = prio[i]; found = 1'b1; end
                m_mcause = 32'h8000_0000 | 32'(code);
                m_mtval  = 0;
            end
        end
        exp_kind = take ? 1 : (ret ? 2 : 0);
        for (int i = SYNC - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = {irq_ext, irq_sw, irq_timer};
    endtask

    task automatic clearInputs();
        rst = 0; csr_rd_en = 0; csr_wr_en = 0; csr_addr = 0; csr_wr_data = 0;
        global_mie = 0; stall = 0; pc = 0; exc_req = 0; exc_cause = 0; exc_tval = 0;
        mret = 0; irq_ext = 0; irq_sw = 0; irq_timer = 0;
    endtask

    // One clock: check the combinational read, step the model, then check the registered outputs.
    task automatic runCycle();
        #1;
        checkOutput("rd_data", csr_rd_data, csr_rd_en ? modelRead(csr_addr) : 32'h0);
        modelStep();
        @(posedge clk);
        @(negedge clk);
        checkOutput("trap", 32'(trap), 32'(exp_kind == 1));
        checkOutput("redirect", 32'(redirect), 32'(exp_kind != 0));
        checkOutput("redirect_pc", redirect_pc,
                    exp_kind == 1 ? modelTarget() : (exp_kind == 2 ? m_mepc : 32'h0));
    endtask

    task automatic readCheck(input string tag, input logic [11:0] a, input logic [31:0] exp);
        csr_rd_en = 1; csr_addr = a;
        #1;
        checkOutput(tag, csr_rd_data, exp);
        csr_rd_en = 0;
    endtask

    task automatic csrWrite(input logic [11:0] a, input logic [31:0] d);
        csr_wr_en = 1; csr_addr = a; csr_wr_data = d;
        runCycle();
        csr_wr_en = 0;
    endtask

    task automatic applyStimulus();
        logic [11:0] addr_list [7] = '{12'h305, 12'h304, 12'h344, 12'h341, 12'h342, 12'h343, 12'h300};
        rst         = ($urandom_range(0, 99) == 0);
        stall       = ($urandom_range(0, 3) == 0);
        exc_req     = ($urandom_range(0, 9) == 0);
        exc_cause   = 4'($urandom);
        exc_tval    = $urandom;
        pc          = $urandom;
        mret        = ($urandom_range(0, 7) == 0);
        irq_ext     = ($urandom_range(0, 3) == 0);
        irq_sw      = ($urandom_range(0, 3) == 0);
        irq_timer   = ($urandom_range(0, 3) == 0);
        global_mie  = ($urandom_range(0, 3) != 0);
        csr_wr_en   = ($urandom_range(0, 5) == 0);
        csr_rd_en   = ($urandom_range(0, 1) == 0);
        csr_addr    = addr_list[$urandom_range(0, 6)];
        csr_wr_data = $urandom;
    endtask

    initial begin
        clearInputs();
        rst = 1;
        exp_kind = 0;
        @(negedge clk);
        runCycle();
        runCycle();
        rst = 0;
        runCycle();
        readCheck("rst_mtvec", 12'h305, 32'h100);
        readCheck("rst_mie", 12'h304, 32'h0);
        readCheck("rst_mip", 12'h344, 32'h0);
        readCheck("rst_mepc", 12'h341, 32'h0);
        readCheck("rst_mcause", 12'h342, 32'h0);
        readCheck("rst_mtval", 12'h343, 32'h0);

        exc_req = 1; exc_cause = 4'd2; pc = 32'h40; exc_tval = 32'hDEAD;
        runCycle();
        checkOutput("exc_trap", 32'(trap), 32'h1);
        checkOutput("exc_target", redirect_pc, 32'h100);
        clearInputs();
        runCycle();
        readCheck("exc_mepc", 12'h341, 32'h40);
        readCheck("exc_mcause", 12'h342, 32'h2);
        readCheck("exc_mtval", 12'h343, 32'hDEAD);

        csrWrite(12'h305, 32'h101);
        csrWrite(12'h304, 32'h880);
        global_mie = 1; irq_ext = 1; irq_timer = 1; pc = 32'h88;
        runCycle();
        runCycle();
`ifdef TRAP_VECTORED_EN
        vec_expect = 32'h100 + 44;
`else
        vec_expect = 32'h100;
`endif
        checkOutput("irq_trap", 32'(trap), 32'h1);
        checkOutput("irq_target", redirect_pc, vec_expect);
        clearInputs();
        runCycle();
        readCheck("irq_mcause", 12'h342, 32'h8000_000B);
        readCheck("irq_mtval", 12'h343, 32'h0);

        global_mie = 1; irq_ext = 1; stall = 1; pc = 32'h90;
        runCycle();
        for (int i = 0; i < 3; i++) begin
            runCycle();
            checkOutput("stall_notrap", 32'(trap), 32'h0);
        end
        stall = 0;
        runCycle();
        checkOutput("stall_trap", 32'(trap), 32'h1);
        clearInputs();
        runCycle();
        checkOutput("stall_once", 32'(trap), 32'h0);
        runCycle();

        csrWrite(12'h341, 32'h207);
        readCheck("mepc_align", 12'h341, 32'h204);
        mret = 1;
        runCycle();
        checkOutput("mret_redirect", 32'(redirect), 32'h1);
        checkOutput("mret_trap", 32'(trap), 32'h0);
        checkOutput("mret_pc", redirect_pc, 32'h204);
        mret = 0;
        runCycle();

        csrWrite(12'h305, 32'h302);
`ifdef TRAP_VECTORED_EN
        vec_expect = 32'h301;
`else
        vec_expect = 32'h300;
`endif
        readCheck("mtvec_mode2", 12'h305, vec_expect);
        exc_req = 1; mret = 1; exc_cause = 4'd3; pc = 32'h500;
        runCycle();
        checkOutput("excmret_trap", 32'(trap), 32'h1);
        clearInputs();
        runCycle();
        checkOutput("excmret_drop", 32'(redirect), 32'h0);

        for (int n = 0; n < 3000; n++) begin
            applyStimulus();
            runCycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
